// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the board's UART transmitter and receiver.
//
// Contents:
//   rx_state_t            receiver FSM state encoding
//   DATA_BITS             payload bits per 8N1 frame
//   DEFAULT_CLKS_PER_BIT  clk cycles per bit (100 MHz / 115200); uart_tx and
//                         uart_rx both default to it so the two ends always
//                         agree on the baud rate.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- brings the asynchronous serial line into the clk domain.
//
// The line passes through a SYNC_STAGES-deep flop chain that resets to 1
// (the idle level), so no false start bit is seen when reset is released.
// One further flop holds the previous synchronized value for edge detection.
//
// Ports:
//   clk      in   receive clock
//   rst      in   asynchronous, active-high reset (presets the chain to 1)
//   rx_data  in   raw serial line, idle high, asynchronous to clk
//   rx_s     out  synchronized line, delayed SYNC_STAGES cycles
//   fall     out  one-cycle strobe: rx_s went from 1 to 0
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_data,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            rx_s_d <= 1'b1;
        end else begin
            sync_q[0] <= rx_data;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            rx_s_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver, LSB first, for the host command link.
//
// Each bit is sampled three times around its centre (cnt = MID-1, MID,
// MID+1) and resolved by majority vote at cnt = MID+1, which rejects single
// cycle glitches. A start bit that votes 1 is treated as noise. Completed
// bytes are offered on a valid/ready handshake; a byte that completes while
// the previous one is still unconsumed is dropped and flagged as an overrun.
// A stop bit that votes 0 is flagged as a framing error and the receiver
// then waits for the line to return high, so a held-low line (break) reports
// only once. CLKS_PER_BIT must be at least 8.
//
// Ports:
//   clk        in   receive clock (clk_mem domain)
//   rst        in   asynchronous, active-high reset; discards a partial byte
//   rx_data    in   serial line, idle high, asynchronous to clk
//   dout       out  received byte, stable while rx_valid is high
//   rx_valid   out  dout holds an unconsumed byte
//   rx_ready   in   consumer takes dout on an edge with rx_valid & rx_ready
//   frame_err  out  one-cycle pulse: stop bit sampled 0
//   overrun    out  one-cycle pulse: byte completed while rx_valid was high
//   busy       out  receiver is inside a frame (state != IDLE)
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_data,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned MID   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    logic rx_s;
    logic fall;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx_data(rx_data),
        .rx_s   (rx_s),
        .fall   (fall)
    );

    rx_state_t            state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [2:0]           bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [1:0]           samp, samp_nxt;
    logic [DATA_BITS-1:0] dout_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;
    logic                 ovr_nxt;

    logic at_dec;
    logic at_last;
    logic maj;

    assign at_dec  = (cnt == CNT_DEC);
    assign at_last = (cnt == CNT_LAST);
    // Third sample is the live line value at the decision point.
    assign maj     = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            samp      <= '0;
            dout      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            samp      <= samp_nxt;
            dout      <= dout_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= ferr_nxt;
            overrun   <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        samp_nxt    = samp;
        dout_nxt    = dout;
        valid_nxt   = rx_valid;
        ferr_nxt    = 1'b0;
        ovr_nxt     = 1'b0;

        // Consumer handshake; a byte loaded below on the same edge overrides.
        if (rx_valid && rx_ready) begin
            valid_nxt = 1'b0;
        end

        // Bit-time counter and the two early samples, shared by all
        // in-frame states.
        if (state == START || state == DATA || state == STOP) begin
            cnt_nxt = at_last ? '0 : cnt + 1'b1;
            if (cnt == CNT_S0) samp_nxt[0] = rx_s;
            if (cnt == CNT_S1) samp_nxt[1] = rx_s;
        end

        case (state)
            IDLE: begin
                if (fall) begin
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end

            START: begin
                if (at_dec && maj) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (at_last) begin
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end
            end

            DATA: begin
                if (at_dec) begin
                    shift_nxt = {maj, shift[DATA_BITS-1:1]};
                end
                if (at_last) begin
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = STOP;
                    end
                end
            end

            STOP: begin
                // Leave at the stop-bit centre rather than its end so the
                // next start edge is never missed on a slightly fast sender.
                if (at_dec) begin
                    cnt_nxt = '0;
                    if (maj) begin
                        if (!rx_valid || rx_ready) begin
                            dout_nxt  = shift;
                            valid_nxt = 1'b1;
                        end else begin
                            ovr_nxt = 1'b1;
                        end
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end

            BREAK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx at 16 clk cycles per bit.
// Line activity is driven in whole clk cycles; outputs are sampled 1 ns
// after the falling clock edge. Frame-error and overrun pulses are counted
// by a monitor and checked as counts.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_data;
    logic       rx_ready;
    logic [7:0] dout;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks    = 0;
    int errors    = 0;
    int ferr_seen = 0;
    int ovr_seen  = 0;
    int ferr_base;
    int ovr_base;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .dout     (dout),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_seen++;
        if (overrun)   ovr_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Hold the line at v for n clk cycles (counted in rising edges).
    task automatic hold(input logic v, input int unsigned n);
        rx_data = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Start bit plus eight data bits, LSB first.
    task automatic send_head(input logic [7:0] b);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_head(b);
        hold(1'b1, CPB);
    endtask

    // Frame at a skewed bit period, given in hundredths of a clk cycle.
    task automatic send_skew(input logic [7:0] b, input int unsigned p100);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int unsigned k = 0; k < 10; k++) begin
            hold(bits[k], ((k + 1) * p100) / 100 - (k * p100) / 100);
        end
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 1'b1;
        rx_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        sample();
        chk("rst_dout", dout, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", {frame_err, overrun}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, 10);

        // 0xA5 at exact baud; rx_valid rises on the edge ending cycle 156
        ferr_base = ferr_seen;
        ovr_base  = ovr_seen;
        send_head(8'hA5);
        hold(1'b1, 12);
        sample();
        chk("a5_valid_before", rx_valid, 1'b0);
        hold(1'b1, 1);
        sample();
        chk("a5_valid_edge", rx_valid, 1'b1);
        hold(1'b1, 30);
        sample();
        chk("a5_valid_held", rx_valid, 1'b1);
        chk("a5_dout", dout, 8'hA5);
        chk("a5_busy", busy, 1'b0);
        accept();
        sample();
        chk("a5_valid_clear", rx_valid, 1'b0);
        chk("a5_dout_kept", dout, 8'hA5);
        chk("a5_no_ferr", ferr_seen - ferr_base, 0);
        chk("a5_no_ovr", ovr_seen - ovr_base, 0);

        // 4-cycle low pulse in IDLE is a false start
        hold(1'b1, 10);
        hold(1'b0, 4);
        hold(1'b1, 4);
        sample();
        chk("glitch_busy_start", busy, 1'b1);
        hold(1'b1, 10);
        sample();
        chk("glitch_busy_idle", busy, 1'b0);
        chk("glitch_valid", rx_valid, 1'b0);
        chk("glitch_no_ferr", ferr_seen - ferr_base, 0);

        // 0x3C with stop held low for three bit times, then 0x7E
        hold(1'b1, 10);
        send_head(8'h3C);
        hold(1'b0, 3 * CPB);
        sample();
        chk("brk_busy_low", busy, 1'b1);
        chk("brk_ferr_one", ferr_seen - ferr_base, 1);
        chk("brk_valid", rx_valid, 1'b0);
        hold(1'b1, 5);
        sample();
        chk("brk_busy_released", busy, 1'b0);
        chk("brk_ferr_still_one", ferr_seen - ferr_base, 1);
        hold(1'b1, 20);
        send_frame(8'h7E);
        hold(1'b1, 8);
        sample();
        chk("7e_valid", rx_valid, 1'b1);
        chk("7e_dout", dout, 8'h7E);
        accept();

        // 0x11 then 0x22 back to back, nobody consuming
        hold(1'b1, 10);
        ovr_base = ovr_seen;
        send_frame(8'h11);
        send_frame(8'h22);
        hold(1'b1, 8);
        sample();
        chk("ovr_count", ovr_seen - ovr_base, 1);
        chk("ovr_dout_old", dout, 8'h11);
        chk("ovr_valid", rx_valid, 1'b1);
        accept();
        sample();
        chk("ovr_valid_clear", rx_valid, 1'b0);

        // Same pair with rx_ready on exactly the second stop decision edge
        hold(1'b1, 10);
        ovr_base = ovr_seen;
        send_frame(8'h11);
        send_head(8'h22);
        hold(1'b1, 12);
        rx_ready = 1'b1;
        hold(1'b1, 1);
        rx_ready = 1'b0;
        sample();
        chk("same_edge_valid", rx_valid, 1'b1);
        chk("same_edge_dout", dout, 8'h22);
        hold(1'b1, 8);
        chk("same_edge_no_ovr", ovr_seen - ovr_base, 0);
        accept();

        // 0xFF with a one-cycle low glitch hitting the cnt=MID sample of bit 3
        hold(1'b1, 10);
        ferr_base = ferr_seen;
        hold(1'b0, CPB);
        for (int i = 0; i < 3; i++) hold(1'b1, CPB);
        hold(1'b1, 9);
        hold(1'b0, 1);
        hold(1'b1, 6);
        for (int i = 4; i < 8; i++) hold(1'b1, CPB);
        hold(1'b1, CPB);
        hold(1'b1, 4);
        sample();
        chk("maj_valid", rx_valid, 1'b1);
        chk("maj_dout", dout, 8'hFF);
        chk("maj_no_ferr", ferr_seen - ferr_base, 0);

        // Reset in the middle of data bit 4 of 0x55, with 0xFF still pending
        hold(1'b1, 10);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        hold(1'b1, 8);
        sample();
        chk("rst_mid_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_dout", dout, 8'h00);
        chk("rst_mid_valid", rx_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, 20);
        send_frame(8'h55);
        hold(1'b1, 8);
        sample();
        chk("55_valid", rx_valid, 1'b1);
        chk("55_dout", dout, 8'h55);
        accept();

        // Sender 3% slow, then 3% fast
        hold(1'b1, 10);
        send_skew(8'h96, 1648);
        hold(1'b1, 8);
        sample();
        chk("slow_valid", rx_valid, 1'b1);
        chk("slow_dout", dout, 8'h96);
        accept();
        hold(1'b1, 10);
        send_skew(8'h96, 1552);
        hold(1'b1, 8);
        sample();
        chk("fast_valid", rx_valid, 1'b1);
        chk("fast_dout", dout, 8'h96);
        accept();
        sample();
        chk("end_valid_clear", rx_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver, 8N1, LSB first; the receive-side counterpart of the board's existing uart_tx.
- Runs on clk_mem at the FPGA top and receives host bytes on the board RX pin.
- Delivers each byte on a valid/ready handshake. Downstream: the command/control logic that will start, stop and reset the cache counters.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per bit (100 MHz / 115200). Must be >= 8.
- SYNC_STAGES, 2: metastability flops on rx_data.

Ports:
- clk  in  1  receive clock (clk_mem domain)
- rst  in  1  asynchronous, active-high reset
- rx_data  in  1  serial line, idle high, asynchronous to clk
- dout  out  8  received byte
- rx_valid  out  1  dout holds an unconsumed byte
- rx_ready  in  1  consumer accepts dout on a clk edge where rx_valid & rx_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- overrun  out  1  one-cycle pulse: byte completed while rx_valid still high
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; cnt=0; bit_idx=0; shift register=0.
  - dout=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops preset to 1.
  - A reset mid-frame discards the partial byte.
- rx_s is the synchronized line, delayed SYNC_STAGES cycles. The falling edge is detected from rx_s and its 1-cycle delayed copy.
- Timing terms:
  - MID = CLKS_PER_BIT/2, integer division.
  - cnt counts 0..CLKS_PER_BIT-1 within each bit and wraps to 0 at the bit boundary.
  - Samples are taken at cnt = MID-1, MID and MID+1. The bit value is the majority of the three, decided at cnt == MID+1.
- IDLE:
  - On a falling edge of rx_s: cnt<=0, go to START.
  - A steady low line in IDLE does not trigger (edge only).
- START:
  - At the decision point, majority 0: continue counting; at cnt wrap go to DATA with bit_idx=0.
  - Majority 1: false start; go to IDLE immediately, no flags.
- DATA:
  - At each decision point the bit is shifted in LSB-first (shift right, MSB inserted).
  - At cnt wrap: bit_idx increments; after bit_idx 7 go to STOP.
- STOP, at the decision point:
  - Majority 1 and rx_valid=0, or rx_valid=1 with rx_ready=1 this cycle: dout<=shift, rx_valid<=1. Go to IDLE on the same edge, so the next start edge can be caught half a bit early.
  - Majority 1 and rx_valid=1 and rx_ready=0: overrun pulses 1 cycle. The new byte is dropped and dout keeps the old byte. Go to IDLE.
  - Majority 0: frame_err pulses 1 cycle, the byte is dropped, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A continuous low line produces exactly one frame_err.
- Handshake:
  - rx_valid deasserts on the edge where rx_valid & rx_ready.
  - dout is stable while rx_valid=1.
  - Accept and new-byte completion on the same edge: the new byte is loaded and rx_valid stays 1, with no overrun.
- Latency: rx_valid rises on the edge at stop-bit cnt==MID+1. Measured from the line's falling start edge, that is about 9.5 bits + SYNC_STAGES + 1 cycles.
- Counter widths:
  - cnt width is $clog2(CLKS_PER_BIT); it never exceeds CLKS_PER_BIT-1.
  - bit_idx is 3 bits.

Decomposition:
- Package uart_pkg holds:
  - the state encoding: IDLE, START, DATA, STOP, BREAK;
  - DATA_BITS=8;
  - the default CLKS_PER_BIT, shared with uart_tx so both ends agree on the baud rate.
- One natural sub-module, uart_rx_sync: a SYNC_STAGES-deep flop chain with async preset to 1. It outputs rx_s and a fall strobe.
- Sampling, the FSM and the handshake stay in uart_rx.

Test Plan (CLKS_PER_BIT=16):
- Send 0xA5 at the exact baud with rx_ready=0 -> rx_valid=1, dout=0xA5, held until rx_ready=1; rx_valid drops on the next edge; frame_err=overrun=0.
- Line pulsed low for 4 cycles in IDLE -> START majority=1, back to IDLE; rx_valid=0, no flags.
- Send 0x3C with stop bit forced 0 for 3 bit-times -> single frame_err pulse, rx_valid=0, busy until line high. A following 0x7E is received correctly.
- Send 0x11 then 0x22 back-to-back with rx_ready=0 -> overrun pulses once at the second stop, dout=0x11. With rx_ready=1 held at the second stop -> dout=0x22, no overrun.
- Send 0xFF with a 1-cycle low glitch at cnt=MID of bit 3 -> majority corrects, dout=0xFF.
- Assert rst during DATA bit 4 of 0x55 -> all outputs 0 immediately. After release, 0x55 is sent again and received correctly. Baud skew of ±3% on 0x96 -> dout=0x96.
